k_rctl_t3: RTL



---
 rtl/k_fifo_pkg.sv | 22 ++
 rtl/k_sync_w2r_t1.sv | 24 ++
 rtl/k_rctl_t3.sv | 61 ++++++
 3 files changed

// File: rtl/k_fifo_pkg.sv
// Shared dual-clock FIFO helpers: Gray/binary conversion and the default pointer size.
// Read-side and write-side control both import this package.
package k_fifo_pkg;

    localparam int ADDR_SIZE_DEF = 4;
    localparam int PTR_MAX_W     = 32;

    // Callers zero-extend their pointer to PTR_MAX_W and size-cast the result back.
    // This lets one function serve every pointer width.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/k_sync_w2r_t1.sv
// Two-flop pointer synchronizer with no logic between the stages.
// The write-side r2w synchronizer uses this same structure.
module k_sync_w2r_t1 #(
    parameter int width = 5
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q2
);

    logic [width-1:0] q1;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            q1 <= d;
            q2 <= q1;
        end
    end

endmodule

// File: rtl/k_rctl_t3.sv
// Read-side FIFO control: holds the binary/Gray read pointers and syncs in the write pointer.
// It also produces the registered empty flag, almost-empty flag and fill level.
module k_rctl_t3
    import k_fifo_pkg::*;
#(
    parameter int addr_size     = ADDR_SIZE_DEF,
    parameter int aempty_thresh = 2
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rinc,
    input  logic [addr_size:0]   wptr,
    output logic                 rempty,
    output logic                 raempty,
    output logic [addr_size-1:0] raddr,
    output logic [addr_size:0]   rptr,
    output logic [addr_size:0]   rq2_wptr,
    output logic [addr_size:0]   rlevel
);

    localparam int P = addr_size + 1;
    localparam logic [addr_size:0] AE_TH = P'(aempty_thresh);

    logic               rget;
    logic [addr_size:0] rbin, rbin_next, rgray_next, wbin, rlevel_next;

    k_sync_w2r_t1 #(.width(P)) u_sync (
        .rclk (rclk),
        .rrst (rrst),
        .d    (wptr),
        .q2   (rq2_wptr)
    );

    always_comb begin
        rget        = rinc & ~rempty;
        rbin_next   = rbin + {{addr_size{1'b0}}, rget};
        rgray_next  = P'(bin2gray(PTR_MAX_W'(rbin_next)));
        wbin        = P'(gray2bin(PTR_MAX_W'(rq2_wptr)));
        // The synced write pointer lags, so the level and flags can only under-report data.
        rlevel_next = wbin - rbin_next;
    end

    assign raddr = rbin[addr_size-1:0];

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin    <= '0;
            rptr    <= '0;
            rlevel  <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
        end else begin
            rbin    <= rbin_next;
            rptr    <= rgray_next;
            rlevel  <= rlevel_next;
            rempty  <= (rgray_next == rq2_wptr);
            raempty <= (rlevel_next <= AE_TH);
        end
    end

endmodule
